i2s_codec_if: RTL
=================

Name: i2s_codec_if

Overview:
- Digital audio interface for the codec. It runs on the 12 MHz output clock of the system PLL and uses the PLL `locked` output to gate start-up.
- It generates the codec bit clock (BCLK) and the shared DAC/ADC LR clock (LRCK) from that clock.
- It serialises 16-bit stereo DAC samples and deserialises ADC samples in standard I2S format, at 48 kHz with default parameters.
- It sits between the PLL and the equalizer datapath: the equalizer produces `tx_*` and consumes `rx_*`.

Parameters:
- DATA_W, 16, sample width per channel.
- BCLK_HALF, 1, clk cycles per BCLK half-period (BCLK = clk/(2*BCLK_HALF)).
- FRAME_BCLKS, 125, BCLK periods per LRCK frame (250 clk per frame at 12 MHz, giving 48 kHz).
- LOCK_WAIT, 1024, clk cycles to wait after synchronised lock before starting.

Ports:
- clk, input, 1, 12 MHz clock from the PLL.
- rst_n, input, 1, asynchronous active-low reset.
- pll_locked, input, 1, PLL lock flag; asynchronous to clk.
- tx_valid, input, 1, a DAC sample pair is offered.
- tx_ready, output, 1, the holding register can accept a pair.
- tx_left, input, DATA_W, left DAC sample (two's complement).
- tx_right, input, DATA_W, right DAC sample.
- rx_valid, output, 1, one-cycle strobe: rx_left/rx_right updated.
- rx_left, output, DATA_W, last left ADC sample.
- rx_right, output, DATA_W, last right ADC sample.
- underrun, output, 1, one-cycle strobe: frame started with no new tx pair.
- running, output, 1, high in RUN state.
- aud_bclk, output, 1, codec bit clock.
- aud_lrck, output, 1, codec DACLRC/ADCLRC; 0 = left, 1 = right.
- aud_dacdat, output, 1, serial DAC data.
- aud_adcdat, input, 1, serial ADC data.

Behaviour:
- Reset (rst_n low, asynchronous) clears every register. Outputs are then 0: aud_bclk, aud_lrck, aud_dacdat, tx_ready, rx_valid, rx_left, rx_right, underrun, running. State goes to IDLE.
- pll_locked passes through a 2-FF synchroniser to give lk.
- States and transitions:
  - IDLE → SETTLE when lk = 1.
  - SETTLE counts LOCK_WAIT cycles, then → RUN.
  - Any state → IDLE in the cycle after lk = 0.
  - Entering IDLE clears the same registers as reset. This includes the holding register, the shift registers and all counters.
  - A mid-frame lock loss therefore truncates the frame and emits no rx_valid for it.
- RUN, counters:
  - Half counter h runs 0..BCLK_HALF-1.
  - BCLK index b runs 0..FRAME_BCLKS-1 and wraps to 0.
  - First RUN cycle: falling tick of b = 0.
  - Falling tick: aud_bclk←0; aud_lrck and aud_dacdat update in the same cycle.
  - Rising tick, BCLK_HALF clk later: aud_bclk←1; aud_adcdat is sampled directly, with no synchroniser, since the codec changes data on BCLK falling.
- RUN, slot layout:
  - HALF = FRAME_BCLKS/2, integer floor (62).
  - aud_lrck = 0 for b < HALF, 1 for b ≥ HALF.
  - Slot s = b (left) or b-HALF (right).
  - s = 0 is the I2S delay slot.
  - s = 1..DATA_W carry bit DATA_W-s, MSB first.
  - s > DATA_W drive 0.
- TX handshake:
  - tx_ready = running & ~hold_full, registered.
  - A transfer happens on tx_valid & tx_ready: the pair is loaded into hold and hold_full is set.
  - At the falling tick of b = 0 with hold_full = 1: hold moves to the tx shift registers and hold_full is cleared. tx_ready rises the next cycle.
  - At b = 0 with hold_full = 0: the previous shift contents are replayed (zero after IDLE) and underrun pulses for 1 cycle.
- RX:
  - Rising ticks of left slots 1..DATA_W shift into rx_l_sh; right slots shift into rx_r_sh.
  - The cycle after the rising tick of right slot DATA_W (b = HALF+DATA_W, 78): rx_left/rx_right ← shift registers and rx_valid = 1 for one cycle.
  - There is no backpressure.
- Simultaneous events: lk falling overrides everything, including the b = 0 load and the rx_valid update.
- Parameter constraint: DATA_W+1 ≤ HALF.

Test Plan:
- rst_n low, or pll_locked = 0 with rst_n high → all outputs 0, tx_ready = 0, aud_bclk static for 5000 cycles.
- pll_locked rises at cycle T → running = 1 at T+2+LOCK_WAIT(+1), and aud_lrck is a 250-clk period with 124 cycles low. aud_bclk toggles every clk.
- tx pair left = 16'hA5C3, right = 16'h0F01 accepted before a frame → aud_dacdat reads 1010010111000011 at left b = 1..16 and 0000111100000001 at right b = 63..78, zero elsewhere. underrun = 0.
- aud_adcdat looped from aud_dacdat with the previous pair → rx_valid pulses once per frame at b = 78 with rx_left = A5C3, rx_right = 0F01.
- No tx_valid for 3 frames → underrun pulses 3 times, one 250 clk apart, and the last pair is replayed.
- pll_locked dropped at b = 40 of a frame → all outputs 0 within 3 clk, no rx_valid for that frame. Restart after relock + LOCK_WAIT, and the first frame replays zero data.

Source files
------------

// File: rtl/i2s_codec_if.sv
// I2S codec interface: BCLK/LRCK generation, 16-bit stereo DAC serialiser and
// ADC deserialiser, gated by a synchronised PLL lock flag.
module i2s_codec_if #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BCLK_HALF   = 1,
    parameter int unsigned FRAME_BCLKS = 125,
    parameter int unsigned LOCK_WAIT   = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_left,
    input  logic [DATA_W-1:0] tx_right,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_left,
    output logic [DATA_W-1:0] rx_right,
    output logic              underrun,
    output logic              running,
    output logic              aud_bclk,
    output logic              aud_lrck,
    output logic              aud_dacdat,
    input  logic              aud_adcdat
);

    localparam int unsigned HALF = FRAME_BCLKS / 2;
    localparam int unsigned B_W  = (FRAME_BCLKS > 1) ? $clog2(FRAME_BCLKS) : 1;
    localparam int unsigned H_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int unsigned S_W  = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // lock synchroniser
    logic              r_lk_meta;
    logic              r_lk;

    // control state
    state_t            r_state;
    state_t            w_state_nxt;
    logic [S_W-1:0]    r_settle_cnt;
    logic [H_W-1:0]    r_h;
    logic              r_phase;
    logic [B_W-1:0]    r_b;

    // transmit path
    logic [DATA_W-1:0] r_hold_l;
    logic [DATA_W-1:0] r_hold_r;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_tx_l_sh;
    logic [DATA_W-1:0] r_tx_r_sh;
    logic              r_tx_ready;
    logic              r_underrun;

    // receive path
    logic [DATA_W-1:0] r_rx_l_sh;
    logic [DATA_W-1:0] r_rx_r_sh;
    logic [DATA_W-1:0] r_rx_left;
    logic [DATA_W-1:0] r_rx_right;
    logic              r_rx_valid;

    // codec pins and status
    logic              r_bclk;
    logic              r_lrck;
    logic              r_dacdat;
    logic              r_running;

    // decoded timing
    logic              w_clr;
    logic              w_run;
    logic              w_run_nxt;
    logic              w_fall;
    logic              w_rise;
    logic              w_left;
    logic [B_W-1:0]    w_slot;
    logic              w_data_slot;
    logic              w_frame_start;
    logic              w_rx_last;
    logic              w_tx_fire;
    logic              w_hold_full_nxt;

    // two-flop synchroniser for the asynchronous PLL lock flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= pll_locked;
            r_lk      <= r_lk_meta;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic; losing lock forces IDLE from anywhere
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_lk) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == S_W'(LOCK_WAIT - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (!r_lk) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_clr     = (w_state_nxt == ST_IDLE);
    assign w_run     = (r_state == ST_RUN);
    assign w_run_nxt = (w_state_nxt == ST_RUN);

    // tick decode: the first RUN cycle is the falling tick of b = 0
    assign w_fall        = w_run && !r_phase && (r_h == '0);
    assign w_rise        = w_run &&  r_phase && (r_h == '0);
    assign w_left        = (r_b < B_W'(HALF));
    assign w_slot        = w_left ? r_b : (r_b - B_W'(HALF));
    assign w_data_slot   = (w_slot != '0) && (w_slot <= B_W'(DATA_W));
    assign w_frame_start = w_fall && (r_b == '0);
    assign w_rx_last     = w_rise && !w_left && (w_slot == B_W'(DATA_W));

    // tx handshake: a hold register refilled by the equalizer, drained at frame start
    assign w_tx_fire       = tx_valid && r_tx_ready;
    assign w_hold_full_nxt = w_tx_fire || (r_hold_full && !w_frame_start);

    // settle counter runs only while waiting for the PLL to stabilise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
        end else if (w_clr || (r_state != ST_SETTLE)) begin
            r_settle_cnt <= '0;
        end else begin
            r_settle_cnt <= r_settle_cnt + S_W'(1);
        end
    end

    // half-period, phase and BCLK-index counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h     <= '0;
            r_phase <= 1'b0;
            r_b     <= '0;
        end else if (w_clr || !w_run) begin
            r_h     <= '0;
            r_phase <= 1'b0;
            r_b     <= '0;
        end else if (r_h == H_W'(BCLK_HALF - 1)) begin
            r_h     <= '0;
            r_phase <= ~r_phase;
            if (r_phase) begin
                r_b <= (r_b == B_W'(FRAME_BCLKS - 1)) ? '0 : (r_b + B_W'(1));
            end
        end else begin
            r_h <= r_h + H_W'(1);
        end
    end

    // hold register, tx shift registers, underrun strobe and tx_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
            r_tx_l_sh   <= '0;
            r_tx_r_sh   <= '0;
            r_underrun  <= 1'b0;
            r_tx_ready  <= 1'b0;
        end else if (w_clr) begin
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
            r_tx_l_sh   <= '0;
            r_tx_r_sh   <= '0;
            r_underrun  <= 1'b0;
            r_tx_ready  <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_frame_start) begin
                if (r_hold_full) begin
                    r_tx_l_sh <= r_hold_l;
                    r_tx_r_sh <= r_hold_r;
                end else begin
                    r_underrun <= 1'b1;
                end
            end else if (w_fall && w_data_slot) begin
                // rotate so the word is intact again for an underrun replay
                if (w_left) begin
                    r_tx_l_sh <= {r_tx_l_sh[DATA_W-2:0], r_tx_l_sh[DATA_W-1]};
                end else begin
                    r_tx_r_sh <= {r_tx_r_sh[DATA_W-2:0], r_tx_r_sh[DATA_W-1]};
                end
            end
            if (w_tx_fire) begin
                r_hold_l <= tx_left;
                r_hold_r <= tx_right;
            end
            r_hold_full <= w_hold_full_nxt;
            r_tx_ready  <= w_run_nxt && !w_hold_full_nxt;
        end
    end

    // codec pins: BCLK, LRCK and DAC data change on the falling tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk   <= 1'b0;
            r_lrck   <= 1'b0;
            r_dacdat <= 1'b0;
        end else if (w_clr) begin
            r_bclk   <= 1'b0;
            r_lrck   <= 1'b0;
            r_dacdat <= 1'b0;
        end else if (w_fall) begin
            r_bclk <= 1'b0;
            r_lrck <= !w_left;
            if (w_data_slot) begin
                r_dacdat <= w_left ? r_tx_l_sh[DATA_W-1] : r_tx_r_sh[DATA_W-1];
            end else begin
                r_dacdat <= 1'b0;
            end
        end else if (w_rise) begin
            r_bclk <= 1'b1;
        end
    end

    // ADC capture on the rising tick; publish both words after the last right bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_l_sh  <= '0;
            r_rx_r_sh  <= '0;
            r_rx_left  <= '0;
            r_rx_right <= '0;
            r_rx_valid <= 1'b0;
        end else if (w_clr) begin
            r_rx_l_sh  <= '0;
            r_rx_r_sh  <= '0;
            r_rx_left  <= '0;
            r_rx_right <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_rise && w_data_slot) begin
                if (w_left) begin
                    r_rx_l_sh <= {r_rx_l_sh[DATA_W-2:0], aud_adcdat};
                end else begin
                    r_rx_r_sh <= {r_rx_r_sh[DATA_W-2:0], aud_adcdat};
                end
            end
            if (w_rx_last) begin
                r_rx_left  <= r_rx_l_sh;
                r_rx_right <= {r_rx_r_sh[DATA_W-2:0], aud_adcdat};
                r_rx_valid <= 1'b1;
            end
        end
    end

    // running flag mirrors the RUN state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
        end else begin
            r_running <= w_run_nxt;
        end
    end

    assign tx_ready   = r_tx_ready;
    assign rx_valid   = r_rx_valid;
    assign rx_left    = r_rx_left;
    assign rx_right   = r_rx_right;
    assign underrun   = r_underrun;
    assign running    = r_running;
    assign aud_bclk   = r_bclk;
    assign aud_lrck   = r_lrck;
    assign aud_dacdat = r_dacdat;

endmodule
